mmio_io_unit: RTL and testbench
===============================

# mmio_io_unit

Memory-mapped I/O unit for the 3-stage RISC-V core, in stage 3 alongside DMEM/BIOS memory. It decodes the IO region (addr[31:30]==2'b10), returns read data with the same 1-cycle latency as the synchronous memories, and handles the UART RX/TX handshakes, including a one-entry TX holding buffer. It also owns a parametrised bank of performance counters: cycle plus N_EVT event counters, with software clear.

## Interface
- N_EVT, 3: number of event counters, 1..16. Event 0 is instruction retired; events 1, 2 are branch instruction and correctly predicted branch by convention.
- CNT_W, 32: counter width, 1..32. Counters are zero-extended on read.
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  stage-3 ALU address
- wdata  in  32  store data (byte in [7:0] for TX)
- re  in  1  load in stage 3 this cycle
- we  in  1  store in stage 3 this cycle
- evt  in  N_EVT  per-cycle event strobes
- rdata  out  32  registered read data, valid the cycle after re
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  RX byte available
- uart_rx_ready  out  1  RX pop strobe
- uart_tx_data  out  8  byte to transmit
- uart_tx_valid  out  1  TX request
- uart_tx_ready  in  1  transmitter accepts
- tx_busy  out  1  TX holding buffer full

## Operation
- hit = addr[31:30]==2'b10. Offsets are addr[7:0]. Upper bits between 29 and 8 are ignored.
- 0x00 ctrl (read):
  - bit0 = TX buffer empty.
  - bit1 = uart_rx_valid.
  - bit2 = tx_overflow (sticky). A read of ctrl clears it at that edge.
- 0x04 RX data (read):
  - rdata <= {24'b0, uart_rx_data}.
  - uart_rx_ready = re & hit & off==0x04 & uart_rx_valid & !rst. Combinational, one cycle.
  - If !uart_rx_valid: no pop, data still returned.
- 0x08 TX data (write):
  - Buffer empty: capture wdata[7:0]; uart_tx_valid=1 next cycle.
  - Buffer full: store dropped, tx_overflow<=1.
- Buffer drains on the cycle uart_tx_valid & uart_tx_ready; it is empty from the next edge. A store on the drain cycle is dropped (buffer still full at decision) and sets overflow.
- Counter 0 (cycle) at 0x10. Event counter k (0..N_EVT-1) at 0x14 for k=0 and 0x18+4k for k>=1 (0x1C, 0x20, ...).
- 0x18 write: clears all counters at that edge. Clear beats increment in the same cycle.
- Cycle counter increments every non-reset cycle. Event k counter increments when evt[k]. Both wrap modulo 2^CNT_W.
- Read of a counter returns its value before that edge's increment.
- Unmapped offsets, !hit, or re=0: rdata <= 0. Writes to read-only or unmapped offsets are ignored.
- re & we both high: treated as write only; rdata <= 0.

## Timing
- Reset values:
  - rdata=0, counters=0, TX buffer empty, uart_tx_valid=0, uart_tx_data=0, tx_overflow=0, tx_busy=0.
  - uart_rx_ready forced 0 while rst.
- Read latency: exactly 1 cycle (re at edge n → rdata valid after edge n+1), matching DMEM.
- TX: store at edge n → uart_tx_valid high after n. With uart_tx_ready held high, it drops after n+1.
- tx_busy = !buffer empty. It is registered state, not combinational from the store.
- Reset mid-transmission: pending byte discarded, uart_tx_valid low after the reset edge.
- TX state machine: EMPTY → (store hit 0x08) → FULL → (valid & ready) → EMPTY. Reset goes to EMPTY from any state.

## Structure
- Shared package io_map_pkg holds:
  - IO_REGION=2'b10.
  - Offset constants: OFF_CTRL, OFF_RX, OFF_TX, OFF_CYC, OFF_INSTR, OFF_CLR, OFF_EVT_BASE.
  - Ctrl bit indices: CTRL_TX_EMPTY, CTRL_RX_VALID, CTRL_TX_OVF.
  - Function evt_offset(k) for the counter address map.
- Sub-module perf_counter_bank(N_EVT, CNT_W) holds the cycle and event counters, the clear, and the indexed read mux.
- UART decode, TX buffer and rdata register stay in the top.

## Test plan
- Reset, then 10 idle cycles; read 0x10 → rdata = 10 one cycle later. Read 0x14 with evt=0 → 0.
- Pulse evt[0] 5 times, then store to 0x18 on the same cycle as an evt[0] pulse. Next read of 0x14 → 0 (clear wins); read 0x10 → small post-clear count.
- uart_tx_ready=0; store 0x41 then 0x42 to 0x08.
  - Required: uart_tx_data=0x41 held, tx_busy=1, ctrl read = 0x4.
  - A second ctrl read → 0x0.
  - Raise ready → one handshake; ctrl bit0 = 1.
- uart_rx_valid=1 with rx_data=0x5A; load 0x04 → uart_rx_ready high exactly that cycle, rdata=0x0000005A next cycle. Repeat with rx_valid=0 → no ready pulse.
- N_EVT=3, CNT_W=8: 300 cycles of evt[2]; read 0x20 → 300 mod 256 = 44. Read unmapped 0x40 → 0. Load at addr 0x10000010 (!hit) → 0.
- Assert rst while TX is FULL and ready=0 → uart_tx_valid=0 and tx_busy=0 after the edge; counters read 0.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared address map for the IO region: region tag, register offsets,
// ctrl bit positions and the performance-counter offset helper.
package io_map_pkg;

  localparam logic [1:0] IO_REGION    = 2'b10;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_RX       = 8'h04;
  localparam logic [7:0] OFF_TX       = 8'h08;
  localparam logic [7:0] OFF_CYC      = 8'h10;
  localparam logic [7:0] OFF_INSTR    = 8'h14;
  localparam logic [7:0] OFF_CLR      = 8'h18;
  localparam logic [7:0] OFF_EVT_BASE = 8'h18;

  localparam int CTRL_TX_EMPTY = 0;
  localparam int CTRL_RX_VALID = 1;
  localparam int CTRL_TX_OVF   = 2;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  // Event 0 keeps the legacy instret slot; the rest follow the clear register.
  function automatic logic [7:0] evt_offset(input int k);
    if (k == 0) return OFF_INSTR;
    return OFF_EVT_BASE + 8'(4 * k);
  endfunction

endpackage

// File: rtl/perf_counter_bank.sv
// Cycle counter plus N_EVT event counters with a shared software clear and
// a combinational, zero-extended read mux indexed by the IO offset.
module perf_counter_bank #(
  parameter int N_EVT = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [N_EVT-1:0] evt,
  input  logic [7:0]       rd_off,
  output logic [31:0]      rd_data
);
  import io_map_pkg::*;

  logic [CNT_W-1:0]       cyc_reg;
  logic [N_EVT*CNT_W-1:0] evt_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cyc_reg <= '0;
    else            cyc_reg <= cyc_reg + CNT_W'(1);
  end

  generate
    for (genvar gi = 0; gi < N_EVT; gi++) begin : g_evt
      logic [CNT_W-1:0] cnt_reg;

      // Clear takes priority over a same-cycle event.
      always_ff @(posedge clk) begin
        if (rst || clr)   cnt_reg <= '0;
        else if (evt[gi]) cnt_reg <= cnt_reg + CNT_W'(1);
      end

      assign evt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (rd_off == OFF_CYC) rd_data[CNT_W-1:0] = cyc_reg;
    for (int k = 0; k < N_EVT; k++) begin
      if (rd_off == evt_offset(k)) rd_data[CNT_W-1:0] = evt_cnt[k*CNT_W +: CNT_W];
    end
  end

endmodule

// File: rtl/mmio_io_unit.sv
// Stage-3 memory-mapped IO: region decode, registered read data with DMEM
// latency, UART RX pop, one-entry TX holding buffer, performance counters.
module mmio_io_unit #(
  parameter int N_EVT = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic             we,
  input  logic [N_EVT-1:0] evt,
  output logic [31:0]      rdata,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  output logic             tx_busy
);
  import io_map_pkg::*;

  logic        hit;
  logic [7:0]  off;
  logic        rd_en;
  logic        wr_en;
  logic        tx_store;
  logic        cnt_clr;
  logic [31:0] cnt_rd;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  tx_state_e   tx_state_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_ovf_reg;
  logic        unused_bits;

  assign hit         = (addr[31:30] == IO_REGION);
  assign off         = addr[7:0];
  assign unused_bits = ^{addr[29:8], wdata[31:8]};

  // A simultaneous load and store is a store; the load has no side effects.
  assign rd_en    = re & ~we & hit;
  assign wr_en    = we & hit;
  assign tx_store = wr_en & (off == OFF_TX);
  assign cnt_clr  = wr_en & (off == OFF_CLR);

  assign uart_rx_ready = rd_en & (off == OFF_RX) & uart_rx_valid & ~rst;

  perf_counter_bank #(
    .N_EVT (N_EVT),
    .CNT_W (CNT_W)
  ) u_counters (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .evt     (evt),
    .rd_off  (off),
    .rd_data (cnt_rd)
  );

  always_comb begin
    rdata_next = '0;
    if (rd_en) begin
      case (off)
        OFF_CTRL: begin
          rdata_next[CTRL_TX_EMPTY] = (tx_state_reg == TX_EMPTY);
          rdata_next[CTRL_RX_VALID] = uart_rx_valid;
          rdata_next[CTRL_TX_OVF]   = tx_ovf_reg;
        end
        OFF_RX:  rdata_next[7:0] = uart_rx_data;
        default: rdata_next      = cnt_rd;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_reg <= '0;
    else     rdata_reg <= rdata_next;
  end

  // TX holding buffer: fullness is decided on the pre-edge state, so a store
  // landing on the drain cycle is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_EMPTY;
      tx_data_reg  <= '0;
      tx_ovf_reg   <= 1'b0;
    end else begin
      if (rd_en && off == OFF_CTRL) tx_ovf_reg <= 1'b0;
      case (tx_state_reg)
        TX_EMPTY: begin
          if (tx_store) begin
            tx_data_reg  <= wdata[7:0];
            tx_state_reg <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (tx_store)      tx_ovf_reg   <= 1'b1;
          if (uart_tx_ready) tx_state_reg <= TX_EMPTY;
        end
        default: tx_state_reg <= TX_EMPTY;
      endcase
    end
  end

  assign rdata         = rdata_reg;
  assign uart_tx_data  = tx_data_reg;
  assign uart_tx_valid = (tx_state_reg == TX_FULL);
  assign tx_busy       = (tx_state_reg == TX_FULL);

endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed bench for mmio_io_unit: a cycle-level reference model checked
// every clock, plus hand-computed expectations along the stimulus sequence.
module tb_mmio_io_unit;

  localparam int N_EVT = 3;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [2:0]  evt;
  logic [31:0] rdata;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  mmio_io_unit #(
    .N_EVT (N_EVT),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .re            (re),
    .we            (we),
    .evt           (evt),
    .rdata         (rdata),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cyc = 0;
  int          m_evc [3] = '{0, 0, 0};
  logic [7:0]  tx_q [$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_txdata = '0;
  int          hs_count = 0;
  int          rx_pulses = 0;

  always @(posedge clk) begin
    bit          h, rd, wr, was_full;
    logic [7:0]  o;
    logic [31:0] r;
    h  = (addr[31:30] == 2'b10);
    o  = addr[7:0];
    rd = re && !we && h;
    wr = we && h;

    chk("rx_ready", {31'b0, uart_rx_ready},
        {31'b0, rd && o == 8'h04 && uart_rx_valid && !rst});
    if (uart_rx_ready) rx_pulses++;
    if (uart_tx_valid && uart_tx_ready) hs_count++;

    if (rst) begin
      m_cyc = 0;
      m_evc = '{0, 0, 0};
      tx_q.delete();
      m_ovf = 1'b0;
      m_rdata = '0;
      m_txdata = '0;
    end else begin
      r = '0;
      if (rd) begin
        case (o)
          8'h00: r = {29'b0, m_ovf, uart_rx_valid, tx_q.size() == 0};
          8'h04: r = {24'b0, uart_rx_data};
          8'h10: r = m_cyc;
          8'h14: r = m_evc[0];
          8'h1C: r = m_evc[1];
          8'h20: r = m_evc[2];
          default: r = '0;
        endcase
        if (o == 8'h00) m_ovf = 1'b0;
      end
      m_rdata = r;

      was_full = (tx_q.size() != 0);
      if (wr && o == 8'h08) begin
        if (was_full) m_ovf = 1'b1;
        else begin
          tx_q.push_back(wdata[7:0]);
          m_txdata = wdata[7:0];
        end
      end
      if (was_full && uart_tx_ready) void'(tx_q.pop_front());

      if (wr && o == 8'h18) begin
        m_cyc = 0;
        m_evc = '{0, 0, 0};
      end else begin
        m_cyc = (m_cyc + 1) % 256;
        for (int k = 0; k < 3; k++) if (evt[k]) m_evc[k] = (m_evc[k] + 1) % 256;
      end
    end

    #1;
    chk("model_rdata", rdata, m_rdata);
    chk("model_tx_valid", {31'b0, uart_tx_valid}, {31'b0, tx_q.size() != 0});
    chk("model_tx_busy", {31'b0, tx_busy}, {31'b0, tx_q.size() != 0});
    if (tx_q.size() != 0) chk("model_tx_data", {24'b0, uart_tx_data}, {24'b0, m_txdata});
  end

  // ---------------- stimulus ----------------
  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d  = rdata;
    $display("rd  addr=0x%08h rdata=0x%08h", a, d);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
    $display("wr  addr=0x%08h wdata=0x%08h", a, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          base;
    rst = 1'b1; addr = '0; wdata = '0; re = 1'b0; we = 1'b0; evt = '0;
    uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_tx_busy", {31'b0, tx_busy}, 32'h0);
    chk("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    addr = 32'h8000_0004; re = 1'b1; uart_rx_valid = 1'b1;
    #1 chk("rst_rx_ready_low", {31'b0, uart_rx_ready}, 32'h0);
    @(negedge clk);
    re = 1'b0; uart_rx_valid = 1'b0; addr = '0; rst = 1'b0;

    // cycle counter after 10 idle cycles
    repeat (10) @(negedge clk);
    do_read(32'h8000_0010, d); chk("cyc_after_10", d, 32'd10);
    do_read(32'h8000_0014, d); chk("instret_idle", d, 32'd0);

    // clear wins over a same-cycle event
    evt = 3'b001;
    repeat (5) @(negedge clk);
    do_write(32'h8000_0018, 32'h0);
    evt = 3'b000;
    do_read(32'h8000_0014, d); chk("instret_cleared", d, 32'd0);
    do_read(32'h8000_0010, d); chk("cyc_post_clear", d, 32'd1);

    // TX buffer full with transmitter stalled, overflow
    uart_tx_ready = 1'b0;
    do_write(32'h8000_0008, 32'h41);
    do_write(32'h8000_0008, 32'h42);
    chk("tx_data_held", {24'b0, uart_tx_data}, 32'h41);
    chk("tx_busy_full", {31'b0, tx_busy}, 32'h1);
    do_read(32'h8000_0000, d); chk("ctrl_ovf", d, 32'h4);
    do_read(32'h8000_0000, d); chk("ctrl_ovf_cleared", d, 32'h0);
    base = hs_count;
    uart_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("tx_one_handshake", hs_count - base, 32'd1);
    do_read(32'h8000_0000, d); chk("ctrl_tx_empty", d, 32'h1);

    // store -> valid for exactly one cycle with ready held high
    do_write(32'h8000_0008, 32'h33);
    chk("tx_valid_after_store", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_data_33", {24'b0, uart_tx_data}, 32'h33);
    @(negedge clk);
    chk("tx_valid_after_drain", {31'b0, uart_tx_valid}, 32'h0);

    // store on the drain cycle is dropped and flags overflow
    do_write(32'h8000_0008, 32'h11);
    do_write(32'h8000_0008, 32'h22);
    chk("drain_cycle_store_dropped", {31'b0, uart_tx_valid}, 32'h0);
    do_read(32'h8000_0000, d); chk("ctrl_drain_ovf", d, 32'h5);
    uart_tx_ready = 1'b0;

    // RX pop
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    base = rx_pulses;
    addr = 32'h8000_0004; re = 1'b1;
    #1 chk("rx_ready_pulse", {31'b0, uart_rx_ready}, 32'h1);
    @(negedge clk);
    re = 1'b0;
    chk("rx_rdata", rdata, 32'h0000_005A);
    chk("rx_one_pulse", rx_pulses - base, 32'd1);
    $display("rd  addr=0x80000004 rdata=0x%08h", rdata);
    uart_rx_valid = 1'b0;
    base = rx_pulses;
    do_read(32'h8000_0004, d); chk("rx_no_valid_data", d, 32'h0000_005A);
    chk("rx_no_pulse", rx_pulses - base, 32'd0);

    // event counter wrap and unmapped / out-of-region reads
    do_write(32'h8000_0018, 32'h0);
    evt = 3'b100;
    repeat (300) @(negedge clk);
    evt = 3'b000;
    do_read(32'h8000_0020, d); chk("evt2_wrap", d, 32'd44);
    do_read(32'h8000_0040, d); chk("unmapped", d, 32'h0);
    do_read(32'h1000_0010, d); chk("not_hit", d, 32'h0);
    do_read(32'h8000_0018, d); chk("clr_reads_zero", d, 32'h0);

    // reset while TX is pending
    do_write(32'h8000_0008, 32'h77);
    chk("tx_busy_before_rst", {31'b0, tx_busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_mid_tx_busy", {31'b0, tx_busy}, 32'h0);
    chk("rst_mid_tx_data", {24'b0, uart_tx_data}, 32'h0);
    do_read(32'h8000_0010, d); chk("rst_cyc_zero", d, 32'h0);
    do_read(32'h8000_0020, d); chk("rst_evt2_zero", d, 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
